// File: rtl/calc1_pkg.sv
// Shared calc1 command/response codes, bus widths and requester state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package calc1_pkg;

    localparam int CMD_W  = 4;
    localparam int RESP_W = 2;
    localparam int DATA_W = 32;

    localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

    localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
    localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
    localparam logic [RESP_W-1:0] RESP_OVF  = 2'd2;
    localparam logic [RESP_W-1:0] RESP_INV  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND1 = 3'd1,
        ST_SEND2 = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/calc1_port_requester_if.sv
// Bundles the upstream op/result handshakes and the calc1 port pins of one requester.
// Latency: n/a (wiring only).
// Backpressure: op_ready / res_ready carry valid-ready flow control in each direction.
interface calc1_port_requester_if;
    import calc1_pkg::*;

    logic              op_valid;
    logic              op_ready;
    logic [CMD_W-1:0]  op_cmd;
    logic [DATA_W-1:0] op_data1;
    logic [DATA_W-1:0] op_data2;
    logic [CMD_W-1:0]  req_cmd_out;
    logic [DATA_W-1:0] req_data_out;
    logic [RESP_W-1:0] resp_in;
    logic [DATA_W-1:0] data_in;
    logic              res_valid;
    logic              res_ready;
    logic [RESP_W-1:0] res_resp;
    logic [DATA_W-1:0] res_data;
    logic              res_timeout;
    logic              proto_err;

    // Requester side.
    modport slave (
        input  op_valid, op_cmd, op_data1, op_data2, resp_in, data_in, res_ready,
        output op_ready, req_cmd_out, req_data_out, res_valid, res_resp, res_data,
               res_timeout, proto_err
    );

    // Upstream driver plus calc1 model side.
    modport master (
        output op_valid, op_cmd, op_data1, op_data2, resp_in, data_in, res_ready,
        input  op_ready, req_cmd_out, req_data_out, res_valid, res_resp, res_data,
               res_timeout, proto_err
    );

endinterface

// File: rtl/calc1_timeout_ctr.sv
// Response-wait counter with synchronous clear/enable and terminal count at TIMEOUT-1.
// Latency: tc_o is combinational from the registered count.
// Backpressure: none; holds its value when not enabled.
module calc1_timeout_ctr #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 10
) (
    input  logic c_clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/calc1_port_requester.sv
// Serialises one upstream op onto a calc1 port (cmd+op1, then op2) and returns the response.
// Latency: pins active 1 edge after handshake; result valid on the edge resp_in is first seen in WAIT.
// Backpressure: op_ready only in IDLE; result held stable in DONE until res_ready.
module calc1_port_requester
    import calc1_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 10
) (
    input  logic                  c_clk,
    input  logic                  reset,
    calc1_port_requester_if.slave bus
);

    state_t            state_q;
    logic [DATA_W-1:0] data2_q;
    logic [CMD_W-1:0]  req_cmd_q;
    logic [DATA_W-1:0] req_data_q;
    logic              res_valid_q;
    logic [RESP_W-1:0] res_resp_q;
    logic [DATA_W-1:0] res_data_q;
    logic              res_timeout_q;
    logic              proto_err_q;

    logic resp_seen;
    logic ctr_tc;
    logic ctr_clr;
    logic ctr_en;

    assign resp_seen = (bus.resp_in != RESP_NONE);
    // Counter restarts while operand 2 is on the pins, so it reads 0 on the first WAIT edge.
    assign ctr_clr   = (state_q == ST_SEND2);
    assign ctr_en    = (state_q == ST_WAIT) && !resp_seen && !ctr_tc;

    calc1_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_ctr (
        .c_clk (c_clk),
        .reset (reset),
        .clr_i (ctr_clr),
        .en_i  (ctr_en),
        .tc_o  (ctr_tc)
    );

    // Main FSM with all outputs registered; a response beats a coincident timeout.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            data2_q       <= '0;
            req_cmd_q     <= CMD_NOP;
            req_data_q    <= '0;
            res_valid_q   <= 1'b0;
            res_resp_q    <= RESP_NONE;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            // A response arriving outside WAIT is a protocol violation; it is never captured.
            if (resp_seen && (state_q != ST_WAIT)) begin
                proto_err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.op_valid) begin
                        if (bus.op_cmd != CMD_NOP) begin
                            data2_q    <= bus.op_data2;
                            req_cmd_q  <= bus.op_cmd;
                            req_data_q <= bus.op_data1;
                            state_q    <= ST_SEND1;
                        end else begin
                            res_resp_q    <= RESP_NONE;
                            res_data_q    <= '0;
                            res_timeout_q <= 1'b0;
                            res_valid_q   <= 1'b1;
                            state_q       <= ST_DONE;
                        end
                    end
                end
                ST_SEND1: begin
                    req_cmd_q  <= CMD_NOP;
                    req_data_q <= data2_q;
                    state_q    <= ST_SEND2;
                end
                ST_SEND2: begin
                    req_data_q <= '0;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (resp_seen) begin
                        res_resp_q    <= bus.resp_in;
                        res_data_q    <= bus.data_in;
                        res_timeout_q <= 1'b0;
                        res_valid_q   <= 1'b1;
                        state_q       <= ST_DONE;
                    end else if (ctr_tc) begin
                        res_resp_q    <= RESP_NONE;
                        res_data_q    <= '0;
                        res_timeout_q <= 1'b1;
                        res_valid_q   <= 1'b1;
                        state_q       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_valid_q && bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.op_ready     = (state_q == ST_IDLE);
    assign bus.req_cmd_out  = req_cmd_q;
    assign bus.req_data_out = req_data_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_resp     = res_resp_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_timeout  = res_timeout_q;
    assign bus.proto_err    = proto_err_q;

endmodule

// File: tb/tb_calc1_port_requester.sv
// Directed bench for calc1_port_requester with TIMEOUT=8; calc1 responses driven by hand.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: res_ready held low for a stretch to confirm the result is held.
module tb_calc1_port_requester;
    import calc1_pkg::*;

    logic c_clk;
    logic reset;
    int   errors;
    int   checks;

    calc1_port_requester_if bus();

    calc1_port_requester #(
        .TIMEOUT (8),
        .CNT_W   (4)
    ) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    // Present one op for a single edge; returns just after the handshake edge.
    task automatic send(input logic [3:0] cmd, input logic [31:0] d1, input logic [31:0] d2);
        bus.op_valid = 1'b1;
        bus.op_cmd   = cmd;
        bus.op_data1 = d1;
        bus.op_data2 = d2;
        step();
        bus.op_valid = 1'b0;
        bus.op_cmd   = CMD_NOP;
        bus.op_data1 = '0;
        bus.op_data2 = '0;
    endtask

    // Pulse res_ready for one edge to retire the held result.
    task automatic accept();
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        reset        = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_cmd   = '0;
        bus.op_data1 = '0;
        bus.op_data2 = '0;
        bus.resp_in  = '0;
        bus.data_in  = '0;
        bus.res_ready = 1'b0;

        // Reset state, observed before any clock edge.
        #3;
        chk("rst_op_ready", 32'(bus.op_ready), 32'd1);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_req_cmd", 32'(bus.req_cmd_out), 32'd0);
        chk("rst_req_data", bus.req_data_out, 32'd0);
        chk("rst_res_data", bus.res_data, 32'd0);
        chk("rst_proto_err", 32'(bus.proto_err), 32'd0);
        #9 reset = 1'b1;
        step();

        // ADD 5+7: pins 1/5, 0/7, 0/0, answer 1/12 on the third WAIT edge.
        send(CMD_ADD, 32'd5, 32'd7);
        chk("add_p1_cmd", 32'(bus.req_cmd_out), 32'd1);
        chk("add_p1_dat", bus.req_data_out, 32'd5);
        chk("add_busy", 32'(bus.op_ready), 32'd0);
        step();
        chk("add_p2_cmd", 32'(bus.req_cmd_out), 32'd0);
        chk("add_p2_dat", bus.req_data_out, 32'd7);
        step();
        chk("add_w_cmd", 32'(bus.req_cmd_out), 32'd0);
        chk("add_w_dat", bus.req_data_out, 32'd0);
        chk("add_w_valid", 32'(bus.res_valid), 32'd0);
        step();
        step();
        bus.resp_in = RESP_OK;
        bus.data_in = 32'd12;
        step();
        bus.resp_in = RESP_NONE;
        bus.data_in = '0;
        chk("add_valid", 32'(bus.res_valid), 32'd1);
        chk("add_resp", 32'(bus.res_resp), 32'd1);
        chk("add_data", bus.res_data, 32'd12);
        chk("add_tmo", 32'(bus.res_timeout), 32'd0);
        accept();
        chk("add_rel_valid", 32'(bus.res_valid), 32'd0);
        chk("add_rel_ready", 32'(bus.op_ready), 32'd1);

        // Silent calc1: result exactly 8 edges after entering WAIT.
        send(CMD_SUB, 32'd9, 32'd3);
        step();
        step();
        repeat (7) step();
        chk("to_early_valid", 32'(bus.res_valid), 32'd0);
        step();
        chk("to_valid", 32'(bus.res_valid), 32'd1);
        chk("to_tmo", 32'(bus.res_timeout), 32'd1);
        chk("to_resp", 32'(bus.res_resp), 32'd0);
        chk("to_data", bus.res_data, 32'd0);

        // Backpressure: result held for 10 cycles with res_ready low.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_tmo", 32'(bus.res_timeout), 32'd1);
            chk("bp_op_ready", 32'(bus.op_ready), 32'd0);
        end
        accept();
        chk("bp_rel_ready", 32'(bus.op_ready), 32'd1);
        chk("bp_rel_valid", 32'(bus.res_valid), 32'd0);

        // Reset while operand 1 is on the pins: clears without a clock edge.
        send(CMD_ADD, 32'h64, 32'h17);
        #2 reset = 1'b0;
        #1;
        chk("rst1_cmd", 32'(bus.req_cmd_out), 32'd0);
        chk("rst1_dat", bus.req_data_out, 32'd0);
        chk("rst1_ready", 32'(bus.op_ready), 32'd1);
        #2 reset = 1'b1;
        step();

        // Reset mid-WAIT, then a fresh op completes normally.
        send(CMD_ADD, 32'h11, 32'h22);
        repeat (4) step();
        #2 reset = 1'b0;
        #1;
        chk("rstw_cmd", 32'(bus.req_cmd_out), 32'd0);
        chk("rstw_dat", bus.req_data_out, 32'd0);
        chk("rstw_valid", 32'(bus.res_valid), 32'd0);
        chk("rstw_ready", 32'(bus.op_ready), 32'd1);
        #2 reset = 1'b1;
        step();
        send(CMD_ADD, 32'h10, 32'h20);
        step();
        step();
        bus.resp_in = RESP_OK;
        bus.data_in = 32'h30;
        step();
        bus.resp_in = RESP_NONE;
        bus.data_in = '0;
        chk("post_rst_valid", 32'(bus.res_valid), 32'd1);
        chk("post_rst_data", bus.res_data, 32'h30);
        accept();
        chk("pre_stray_perr", 32'(bus.proto_err), 32'd0);

        // Stray response in IDLE sets sticky proto_err and is not captured.
        bus.resp_in = RESP_OK;
        bus.data_in = 32'h55;
        step();
        bus.resp_in = RESP_NONE;
        bus.data_in = '0;
        chk("stray_perr", 32'(bus.proto_err), 32'd1);
        chk("stray_valid", 32'(bus.res_valid), 32'd0);
        chk("stray_ready", 32'(bus.op_ready), 32'd1);
        send(CMD_SHL, 32'd3, 32'd2);
        step();
        step();
        bus.resp_in = RESP_OK;
        bus.data_in = 32'd12;
        step();
        bus.resp_in = RESP_NONE;
        bus.data_in = '0;
        chk("stray_op_valid", 32'(bus.res_valid), 32'd1);
        chk("stray_op_data", bus.res_data, 32'd12);
        chk("stray_perr_hold", 32'(bus.proto_err), 32'd1);
        accept();

        // No-op: no pin activity, zero result on the next edge.
        send(CMD_NOP, 32'hAA, 32'hBB);
        chk("nop_cmd", 32'(bus.req_cmd_out), 32'd0);
        chk("nop_dat", bus.req_data_out, 32'd0);
        chk("nop_valid", 32'(bus.res_valid), 32'd1);
        chk("nop_resp", 32'(bus.res_resp), 32'd0);
        chk("nop_data", bus.res_data, 32'd0);
        chk("nop_tmo", 32'(bus.res_timeout), 32'd0);
        accept();
        chk("nop_rel_ready", 32'(bus.op_ready), 32'd1);

        // Only reset clears proto_err.
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        chk("perr_cleared", 32'(bus.proto_err), 32'd0);
        step();

        // Response on the same edge as the timeout wins and is not a protocol error.
        send(CMD_SHR, 32'd1, 32'd2);
        step();
        step();
        repeat (7) step();
        bus.resp_in = RESP_OVF;
        bus.data_in = 32'hDEAD;
        step();
        bus.resp_in = RESP_NONE;
        bus.data_in = '0;
        chk("tie_valid", 32'(bus.res_valid), 32'd1);
        chk("tie_tmo", 32'(bus.res_timeout), 32'd0);
        chk("tie_resp", 32'(bus.res_resp), 32'd2);
        chk("tie_data", bus.res_data, 32'hDEAD);
        chk("tie_perr", 32'(bus.proto_err), 32'd0);
        accept();
        chk("tie_rel_ready", 32'(bus.op_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
